// File: rtl/pipTypes.sv
// Shared pipeline types for the MEM-stage load/store path.
package pipTypes;

  typedef enum logic [1:0] {
    OP_LS_BYTE     = 2'd0,
    OP_LS_HALFWORD = 2'd1,
    OP_LS_WORD     = 2'd2,
    OP_LS_DWORD    = 2'd3
  } ls_op_t;

  typedef enum logic [1:0] {
    FWD_NONE            = 2'd0,
    FWD_FROM_EXMEM      = 2'd1,
    FWD_FROM_MEMWB      = 2'd2,
    FWD_FROM_MEMWB_LATE = 2'd3
  } fwd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HELD = 2'd2
  } lsu_state_t;

  // Access size in bytes for a load/store opcode.
  function automatic int unsigned op_bytes(input ls_op_t op);
    case (op)
      OP_LS_BYTE:     op_bytes = 1;
      OP_LS_HALFWORD: op_bytes = 2;
      OP_LS_WORD:     op_bytes = 4;
      default:        op_bytes = 8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane steering: store placement, byte enables, load extraction
// and sign extension, plus misalignment decode. Purely combinational.
module lsu_align
  import pipTypes::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH = $clog2(BE_WIDTH)
) (
  input  ls_op_t                  op,
  input  logic                    sext,
  input  logic [OFF_WIDTH-1:0]    off,
  input  logic [DATA_WIDTH-1:0]   st_word,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [BE_WIDTH-1:0]     be,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    misaligned
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  int unsigned           nbytes;
  int unsigned           lane_lo;
  int unsigned           sbit;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] keep;

  // Lowest lane touched is BE_WIDTH-offset-size; everything shifts from there.
  always_comb begin
    nbytes     = op_bytes(op);
    misaligned = (nbytes > BE_WIDTH) || ((32'(off) & (nbytes - 32'd1)) != 32'd0);
    lane_lo    = misaligned ? 32'd0 : (BE_WIDTH - 32'(off) - nbytes);
    sbit       = misaligned ? (DATA_WIDTH - 32'd1) : (32'd8 * nbytes - 32'd1);
    wr_data    = st_word << (32'd8 * lane_lo);
    be         = misaligned ? '0 : (BE_WIDTH'((32'd1 << nbytes) - 32'd1) << lane_lo);
    raw        = rd_data >> (32'd8 * lane_lo);
    keep       = ~({DATA_WIDTH{1'b1}} << (32'd8 * nbytes));
    ld_data    = raw & keep;
    if (sext && raw[IDX_W'(sbit)]) ld_data = ld_data | ~keep;
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: cache handshake FSM, store-operand retention
// across waitrequest and load-result retention across downstream hold.
module lsu
  import pipTypes::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH = $clog2(BE_WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_inst,
  input  logic                   store_inst,
  input  ls_op_t                 ls_op,
  input  logic                   ls_sext,
  input  logic [ADDR_WIDTH-1:0]  agu_result,
  input  logic [DATA_WIDTH-1:0]  store_data,
  input  logic [DATA_WIDTH-1:0]  result_from_mem_wb,
  input  fwd_t                   B_fwd_from,
  input  logic                   hold_in,
  output logic                   cache_rd,
  output logic                   cache_wr,
  output logic [ADDR_WIDTH-1:0]  cache_addr,
  output logic [DATA_WIDTH-1:0]  cache_wr_data,
  output logic [BE_WIDTH-1:0]    cache_wr_be,
  input  logic [DATA_WIDTH-1:0]  cache_data,
  input  logic                   cache_waitrequest,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   stall,
  output logic                   exc_misaligned
);

  lsu_state_t            state, next_state;
  logic [DATA_WIDTH-1:0] st_q, ld_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;

  logic [DATA_WIDTH-1:0] operand, wr_data_c, ld_c, cur_result;
  logic [BE_WIDTH-1:0]   be_c;
  logic                  misaligned_c, access, issue, done, cur_wr;

  assign access  = load_inst | store_inst;
  assign operand = (B_fwd_from == FWD_FROM_MEMWB_LATE) ? result_from_mem_wb : store_data;
  assign issue   = (state == ST_IDLE) & access & ~misaligned_c;
  assign done    = ((state == ST_BUSY) | issue) & ~cache_waitrequest;
  assign cur_wr  = (state == ST_BUSY) ? wr_q : store_inst;
  assign cur_result = cur_wr ? DATA_WIDTH'(agu_result) : ld_c;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_align (
    .op         (ls_op),
    .sext       (ls_sext),
    .off        (agu_result[OFF_WIDTH-1:0]),
    .st_word    (operand),
    .rd_data    (cache_data),
    .wr_data    (wr_data_c),
    .be         (be_c),
    .ld_data    (ld_c),
    .misaligned (misaligned_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (issue && cache_waitrequest) next_state = ST_BUSY;
        else if (issue && hold_in)      next_state = ST_HELD;
      end
      ST_BUSY: if (!cache_waitrequest) next_state = hold_in ? ST_HELD : ST_IDLE;
      ST_HELD: if (!hold_in)           next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request snapshot on entry to BUSY; completed result snapshot on entry to HELD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= '0;
      be_q   <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      ld_q   <= '0;
    end else begin
      if (issue && cache_waitrequest) begin
        st_q   <= wr_data_c;
        be_q   <= be_c;
        addr_q <= agu_result;
        wr_q   <= store_inst;
      end
      if (done && hold_in) ld_q <= cur_result;
    end
  end

  always_comb begin
    cache_rd       = 1'b0;
    cache_wr       = 1'b0;
    cache_addr     = agu_result >> OFF_WIDTH;
    cache_wr_data  = wr_data_c;
    cache_wr_be    = '0;
    result         = DATA_WIDTH'(agu_result);
    stall          = 1'b0;
    exc_misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && misaligned_c) begin
          exc_misaligned = 1'b1;
        end else if (access) begin
          cache_rd    = ~store_inst;
          cache_wr    = store_inst;
          cache_wr_be = store_inst ? be_c : '0;
          stall       = cache_waitrequest;
          result      = cur_result;
        end
      end
      ST_BUSY: begin
        cache_rd      = ~wr_q;
        cache_wr      = wr_q;
        cache_addr    = addr_q >> OFF_WIDTH;
        cache_wr_data = st_q;
        cache_wr_be   = wr_q ? be_q : '0;
        stall         = cache_waitrequest;
        result        = cur_result;
      end
      ST_HELD: begin
        stall  = 1'b1;
        result = ld_q;
      end
      default: ;
    endcase
    if (!reset_n) begin
      cache_rd       = 1'b0;
      cache_wr       = 1'b0;
      cache_wr_be    = '0;
      stall          = 1'b0;
      exc_misaligned = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one 32-bit and one 64-bit instance on a shared clock.
module tb_lsu;
  import pipTypes::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // 32-bit instance
  logic a_load, a_store, a_sext, a_hold, a_wait, a_rd, a_wr, a_stall, a_exc;
  ls_op_t a_op;
  fwd_t a_fwd;
  logic [31:0] a_agu, a_sd, a_rfw, a_addr, a_wdata, a_cdata, a_result;
  logic [3:0] a_be;

  // 64-bit instance
  logic b_load, b_store, b_sext, b_hold, b_wait, b_rd, b_wr, b_stall, b_exc;
  ls_op_t b_op;
  fwd_t b_fwd;
  logic [31:0] b_agu, b_addr;
  logic [63:0] b_sd, b_rfw, b_wdata, b_cdata, b_result;
  logic [7:0] b_be;

  lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .load_inst(a_load), .store_inst(a_store),
    .ls_op(a_op), .ls_sext(a_sext), .agu_result(a_agu), .store_data(a_sd),
    .result_from_mem_wb(a_rfw), .B_fwd_from(a_fwd), .hold_in(a_hold),
    .cache_rd(a_rd), .cache_wr(a_wr), .cache_addr(a_addr), .cache_wr_data(a_wdata),
    .cache_wr_be(a_be), .cache_data(a_cdata), .cache_waitrequest(a_wait),
    .result(a_result), .stall(a_stall), .exc_misaligned(a_exc)
  );

  lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .load_inst(b_load), .store_inst(b_store),
    .ls_op(b_op), .ls_sext(b_sext), .agu_result(b_agu), .store_data(b_sd),
    .result_from_mem_wb(b_rfw), .B_fwd_from(b_fwd), .hold_in(b_hold),
    .cache_rd(b_rd), .cache_wr(b_wr), .cache_addr(b_addr), .cache_wr_data(b_wdata),
    .cache_wr_be(b_be), .cache_data(b_cdata), .cache_waitrequest(b_wait),
    .result(b_result), .stall(b_stall), .exc_misaligned(b_exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_load = 0; a_store = 0; a_sext = 0; a_hold = 0; a_wait = 0;
    a_op = OP_LS_BYTE; a_fwd = FWD_NONE;
    a_agu = '0; a_sd = '0; a_rfw = '0; a_cdata = '0;
  endtask

  task automatic b_idle();
    b_load = 0; b_store = 0; b_sext = 0; b_hold = 0; b_wait = 0;
    b_op = OP_LS_BYTE; b_fwd = FWD_NONE;
    b_agu = '0; b_sd = '0; b_rfw = '0; b_cdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_idle();
    b_idle();
    // Strobes forced low during reset even with a valid request present
    a_load = 1; a_op = OP_LS_WORD; a_agu = 32'h100;
    #2;
    check("rst_rd", a_rd, 0);
    check("rst_stall", a_stall, 0);
    tick();
    reset_n = 1'b1;
    a_idle();
    #1;
    check("idle_rd", a_rd, 0);
    check("idle_wr", a_wr, 0);

    // Store BYTE 0xA5 at 0x1002, no wait
    tick();
    a_store = 1; a_op = OP_LS_BYTE; a_agu = 32'h1002; a_sd = 32'h0000_00A5;
    #1;
    check("sb_wr", a_wr, 1);
    check("sb_addr", a_addr, 32'h400);
    check("sb_be", a_be, 4'b0010);
    check("sb_data", a_wdata, 32'h0000_A500);
    check("sb_stall", a_stall, 0);

    // Store HALFWORD and WORD lane placement
    tick();
    a_op = OP_LS_HALFWORD; a_agu = 32'h1002; a_sd = 32'h0000_BEEF;
    #1;
    check("sh_be", a_be, 4'b0011);
    check("sh_data", a_wdata, 32'h0000_BEEF);
    tick();
    a_op = OP_LS_HALFWORD; a_agu = 32'h1000; a_sd = 32'h0000_BEEF;
    #1;
    check("sh0_be", a_be, 4'b1100);
    check("sh0_data", a_wdata, 32'hBEEF_0000);
    tick();
    a_op = OP_LS_WORD; a_agu = 32'h1004; a_sd = 32'h1234_5678;
    #1;
    check("sw_be", a_be, 4'b1111);
    check("sw_addr", a_addr, 32'h401);

    // Loads: HALFWORD sext/zext and BYTE extraction
    tick();
    a_idle();
    a_load = 1; a_op = OP_LS_HALFWORD; a_sext = 1; a_agu = 32'h2002; a_cdata = 32'h1234_8001;
    #1;
    check("lh_rd", a_rd, 1);
    check("lh_be", a_be, 4'b0000);
    check("lh_sext", a_result, 32'hFFFF_8001);
    tick();
    a_sext = 0;
    #1;
    check("lh_zext", a_result, 32'h0000_8001);
    tick();
    a_op = OP_LS_BYTE; a_sext = 1; a_agu = 32'h2002;
    #1;
    check("lb_sext", a_result, 32'hFFFF_FF80);
    tick();
    a_agu = 32'h2000;
    #1;
    check("lb_o0", a_result, 32'h0000_0012);

    // Late-forwarded store with 3 wait cycles
    tick();
    a_idle();
    a_store = 1; a_op = OP_LS_WORD; a_agu = 32'h3000; a_fwd = FWD_FROM_MEMWB_LATE;
    a_sd = 32'hDEAD_DEAD; a_rfw = 32'hCAFE_0001; a_wait = 1;
    #1;
    check("fw0_data", a_wdata, 32'hCAFE_0001);
    check("fw0_stall", a_stall, 1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      a_rfw = 32'hCAFE_0001 + 32'(i);
      #1;
      check("fwN_wr", a_wr, 1);
      check("fwN_data", a_wdata, 32'hCAFE_0001);
      check("fwN_stall", a_stall, 1);
    end
    tick();
    a_rfw = 32'hCAFE_0004; a_wait = 0;
    #1;
    check("fw3_data", a_wdata, 32'hCAFE_0001);
    check("fw3_be", a_be, 4'b1111);
    check("fw3_stall", a_stall, 0);
    tick();
    a_idle();
    #1;
    check("fw_idle_wr", a_wr, 0);
    check("fw_idle_stall", a_stall, 0);

    // Misaligned accesses
    tick();
    a_load = 1; a_op = OP_LS_WORD; a_agu = 32'h13;
    #1;
    check("mis_exc", a_exc, 1);
    check("mis_rd", a_rd, 0);
    check("mis_result", a_result, 32'h13);
    check("mis_stall", a_stall, 0);
    tick();
    a_idle();
    #1;
    check("mis_pulse", a_exc, 0);
    tick();
    a_load = 1; a_op = OP_LS_DWORD; a_agu = 32'h10;
    #1;
    check("dw32_exc", a_exc, 1);
    check("dw32_rd", a_rd, 0);
    tick();
    a_idle();
    a_store = 1; a_op = OP_LS_HALFWORD; a_agu = 32'h1001;
    #1;
    check("mis_st_exc", a_exc, 1);
    check("mis_st_wr", a_wr, 0);
    check("mis_st_be", a_be, 4'b0000);

    // Reset asserted while BUSY
    tick();
    a_idle();
    a_load = 1; a_op = OP_LS_WORD; a_agu = 32'h4000; a_wait = 1;
    #1;
    check("rb_rd0", a_rd, 1);
    tick();
    #1;
    check("rb_busy_rd", a_rd, 1);
    reset_n = 1'b0;
    #1;
    check("rb_rst_rd", a_rd, 0);
    check("rb_rst_stall", a_stall, 0);
    tick();
    reset_n = 1'b1;
    a_idle();
    #1;
    check("rb_after_rd", a_rd, 0);
    check("rb_after_stall", a_stall, 0);

    // 64-bit WORD load held downstream for 2 cycles
    tick();
    b_load = 1; b_op = OP_LS_WORD; b_agu = 32'h0C; b_cdata = 64'h1111_2222_8765_4321; b_hold = 1;
    #1;
    check("h0_rd", b_rd, 1);
    check("h0_addr", b_addr, 32'h1);
    check("h0_result", b_result, 64'h0000_0000_8765_4321);
    check("h0_stall", b_stall, 0);
    tick();
    b_cdata = 64'h0;
    #1;
    check("h1_rd", b_rd, 0);
    check("h1_result", b_result, 64'h0000_0000_8765_4321);
    check("h1_stall", b_stall, 1);
    tick();
    b_hold = 0;
    #1;
    check("h2_rd", b_rd, 0);
    check("h2_result", b_result, 64'h0000_0000_8765_4321);
    tick();
    b_idle();
    #1;
    check("h3_rd", b_rd, 0);
    check("h3_stall", b_stall, 0);

    // 64-bit lane checks
    tick();
    b_load = 1; b_op = OP_LS_WORD; b_agu = 32'h08; b_cdata = 64'h1111_2222_8765_4321;
    #1;
    check("w64_hi", b_result, 64'h0000_0000_1111_2222);
    tick();
    b_agu = 32'h0C; b_sext = 1;
    #1;
    check("w64_sext", b_result, 64'hFFFF_FFFF_8765_4321);
    tick();
    b_idle();
    b_store = 1; b_op = OP_LS_DWORD; b_agu = 32'h10; b_sd = 64'h0102_0304_0506_0708;
    #1;
    check("sd_be", b_be, 8'hFF);
    check("sd_data", b_wdata, 64'h0102_0304_0506_0708);
    tick();
    b_agu = 32'h14;
    #1;
    check("sd_mis_exc", b_exc, 1);
    check("sd_mis_wr", b_wr, 0);
    tick();
    b_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit for the MEM stage: drives the data-cache port, steers and sign-extends sub-word loads, and places stores into byte lanes with exact byte enables. Supports 32- or 64-bit data paths. Unlike a single-cycle stage, it detects misaligned accesses, holds the cache request stable across waitrequest, retains late-forwarded store data, and keeps a completed load result while downstream is stalled. It sits between EX/MEM and MEM/WB, with the cache behind it.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, cache data width; 32 or 64 only
- BE_WIDTH, DATA_WIDTH/8, byte enables; OFF_WIDTH = $clog2(BE_WIDTH) derived as a localparam
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_inst, store_inst  in  1 each  access request for the current instruction
- ls_op  in  ls_op_t  BYTE / HALFWORD / WORD / DWORD
- ls_sext  in  1  sign-extend sub-word load
- agu_result  in  ADDR_WIDTH  byte address
- store_data  in  DATA_WIDTH  store operand from EX/MEM
- result_from_mem_wb  in  DATA_WIDTH  late forward source
- B_fwd_from  in  fwd_t  FWD_FROM_MEMWB_LATE selects result_from_mem_wb as store operand
- hold_in  in  1  downstream stall
- cache_rd, cache_wr  out  1 each  cache strobes
- cache_addr  out  ADDR_WIDTH  word address = agu_result >> OFF_WIDTH
- cache_wr_data  out  DATA_WIDTH  lane-placed store word
- cache_wr_be  out  BE_WIDTH  byte enables; 0 unless cache_wr
- cache_data  in  DATA_WIDTH  read data
- cache_waitrequest  in  1  cache not ready
- result  out  DATA_WIDTH  load data, else agu_result zero-extended
- stall  out  1  upstream must hold inputs
- exc_misaligned  out  1  address-error pulse for the current instruction

## Operation
- Lane order is big-endian: byte offset o maps to lane BE_WIDTH-1-o. HALFWORD uses lanes at o and o+1. WORD uses 4 lanes. DWORD uses all 8.
- Misaligned when: HALFWORD and o[0]; WORD and o[1:0]!=0; DWORD and o!=0. DWORD with DATA_WIDTH=32 is always misaligned.
- Misaligned accesses issue no strobe, pulse exc_misaligned for one cycle, and set result = agu_result. No stall.
- load_inst and store_inst both high: treated as a store.
- Loads: extract the selected lanes into the low bits. Upper bits are sign-extended when ls_sext, otherwise zeroed. WORD on a 64-bit path obeys ls_sext.
- State machine (lsu_state_t): IDLE, BUSY, HELD.
  - IDLE: a valid access drives strobes combinationally. If waitrequest is high, go to BUSY and capture the placed store word and BE into st_q. Else the access completes this cycle; if hold_in is high, capture the load result into ld_q and go to HELD.
  - BUSY: strobes, address, BE, and data (from st_q) stay constant. On the first cycle with waitrequest low, complete; then go to HELD if hold_in, else IDLE.
  - HELD: strobes low, result = ld_q. Return to IDLE when hold_in falls.
- stall = (strobe & cache_waitrequest) | (state==HELD) | hold_in-not-applicable. stall is only the cache-wait and HELD terms; upstream OR's hold_in separately.

## Timing
- Reset: state=IDLE, st_q=0, ld_q=0. Strobes forced 0 while reset_n is low.
- Reset asserted in BUSY or HELD abandons the access; no replay.
- Latency: zero-wait access completes in the issue cycle. N wait cycles give N stall cycles.
- Forward retention: st_q is captured on the IDLE→BUSY edge, so a later change of result_from_mem_wb does not alter the write data.
- exc_misaligned and strobes are mutually exclusive in every cycle.

## Structure
- Package pipTypes holds ls_op_t (adds OP_LS_DWORD), fwd_t, and lsu_state_t.
- Sub-module lsu_align is combinational and handles lane placement, BE generation, load extraction/extension, and misalignment decode.
- lsu holds the FSM and the st_q/ld_q registers.

## Test plan
- 32-bit store BYTE 0xA5 at addr 0x1002, no wait → cache_addr=0x400, be=0010, wr_data[15:8]=0xA5, stall=0.
- 32-bit load HALFWORD sext at 0x2002, cache_data=0x1234_8001 → result=0xFFFF_8001. Repeat with ls_sext=0 → 0x0000_8001.
- Store with FWD_FROM_MEMWB_LATE, 3 wait cycles, result_from_mem_wb changing each cycle → wr_data constant at the cycle-0 value, stall high for 3 cycles.
- Load WORD at 0x13 → exc_misaligned=1 for 1 cycle, no strobe, result=0x13. DWORD on a 32-bit path → exception.
- 64-bit load WORD at 0x0C, cache_data=0x1111_2222_8765_4321, hold_in high 2 cycles → result=0x8765_4321 for 3 cycles, cache_rd high in cycle 0 only.
- reset_n low during BUSY → strobes drop immediately, state=IDLE after release.
